// File: rtl/pipelined_byte_memory_if.sv
// Core-side memory bus: byte address, read strobe with valid/busy handshake,
// per-byte masked write data and an address-error pulse.
interface pipelined_byte_memory_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic [31:0]           mem_addr;
  logic                  mem_rstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_rbusy;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wmask;
  logic                  mem_err;

  modport master (
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rvalid, mem_rbusy, mem_err
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output mem_rdata, mem_rvalid, mem_rbusy, mem_err
  );
endinterface

// File: rtl/pipelined_byte_memory.sv
// Single-port synchronous RAM with byte write enables, a READ_LATENCY-deep
// read pipeline (stage 0 is the RAM output register) and address-error pulses.
module pipelined_byte_memory #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          WORDS        = 1536,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1,
  parameter              INIT_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      resetn,
  pipelined_byte_memory_if.slave    bus
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                   ram_q [WORDS];

  logic [31:0]             off;
  logic [31:0]             idx;
  logic [AW-1:0]           ram_idx;
  logic                    in_range;
  logic                    aligned;
  logic                    addr_ok;
  logic                    access;
  word_t                   rd_word;

  word_t                   data_q [READ_LATENCY];
  word_t                   data_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] valid_d;
  logic                    err_pend_q, err_pend_d;
  logic                    err_q, err_d;
  logic                    rbusy;

  // Below BASE_ADDR the subtraction wraps to a huge offset, so the explicit
  // >= compare is what rejects those addresses.
  always_comb begin
    off      = bus.mem_addr - BASE_ADDR;
    idx      = off >> LANE_BITS;
    in_range = (bus.mem_addr >= BASE_ADDR) && (idx < 32'(WORDS));
    aligned  = (off & 32'(NB - 1)) == 32'd0;
    addr_ok  = in_range && aligned;
    access   = bus.mem_rstrb || (|bus.mem_wmask);
    ram_idx  = idx[AW-1:0];
    rd_word  = addr_ok ? ram_q[ram_idx] : '0;
  end

  // NOTE: the RAM array has no reset; clearing it would forbid block-RAM mapping
  // and the contents are meant to survive resetn.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.mem_wmask[k]) ram_q[ram_idx][k*8 +: 8] <= bus.mem_wdata[k*8 +: 8];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    // Stage 0 samples the array with the same edge that commits a write, so a
    // same-word read sees the old contents.
    valid_d[0] = bus.mem_rstrb;
    if (bus.mem_rstrb) data_d[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end

    rbusy = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) rbusy = rbusy | valid_q[i];

    err_pend_d = access && !addr_ok;
    err_d      = err_pend_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= data_d[i];
    end
  end

  assign bus.mem_rdata  = data_q[READ_LATENCY-1];
  assign bus.mem_rvalid = valid_q[READ_LATENCY-1];
  assign bus.mem_rbusy  = rbusy;
  assign bus.mem_err    = err_q;
endmodule

// File: tb/tb_pipelined_byte_memory.sv
// Directed bench: four instances cover latency 1/3/4, a non-zero base address
// with a small depth, byte masks, read-before-write, errors and async reset.
module tb_pipelined_byte_memory;
  logic clk = 1'b0;
  logic resetn;
  logic rst_d_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipelined_byte_memory_if #(.DATA_WIDTH(32)) if_a ();
  pipelined_byte_memory_if #(.DATA_WIDTH(32)) if_b ();
  pipelined_byte_memory_if #(.DATA_WIDTH(32)) if_c ();
  pipelined_byte_memory_if #(.DATA_WIDTH(32)) if_d ();

  pipelined_byte_memory #(.DATA_WIDTH(32), .WORDS(1536), .BASE_ADDR(32'h0),
                          .READ_LATENCY(1)) dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
  pipelined_byte_memory #(.DATA_WIDTH(32), .WORDS(64), .BASE_ADDR(32'h0),
                          .READ_LATENCY(3)) dut_b (.clk(clk), .resetn(resetn), .bus(if_b));
  pipelined_byte_memory #(.DATA_WIDTH(32), .WORDS(16), .BASE_ADDR(32'h1000),
                          .READ_LATENCY(1)) dut_c (.clk(clk), .resetn(resetn), .bus(if_c));
  pipelined_byte_memory #(.DATA_WIDTH(32), .WORDS(64), .BASE_ADDR(32'h0),
                          .READ_LATENCY(4)) dut_d (.clk(clk), .resetn(rst_d_n), .bus(if_d));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then read 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [31:0] a, input logic rs, input logic [31:0] wd, input logic [3:0] wm);
    if_a.mem_addr = a; if_a.mem_rstrb = rs; if_a.mem_wdata = wd; if_a.mem_wmask = wm;
  endtask
  task automatic drv_b(input logic [31:0] a, input logic rs, input logic [31:0] wd, input logic [3:0] wm);
    if_b.mem_addr = a; if_b.mem_rstrb = rs; if_b.mem_wdata = wd; if_b.mem_wmask = wm;
  endtask
  task automatic drv_c(input logic [31:0] a, input logic rs, input logic [31:0] wd, input logic [3:0] wm);
    if_c.mem_addr = a; if_c.mem_rstrb = rs; if_c.mem_wdata = wd; if_c.mem_wmask = wm;
  endtask
  task automatic drv_d(input logic [31:0] a, input logic rs, input logic [31:0] wd, input logic [3:0] wm);
    if_d.mem_addr = a; if_d.mem_rstrb = rs; if_d.mem_wdata = wd; if_d.mem_wmask = wm;
  endtask

  initial begin
    int rv_seen;
    resetn  = 1'b0;
    rst_d_n = 1'b0;
    drv_a(32'h0, 1'b0, 32'h0, 4'h0);
    drv_b(32'h0, 1'b0, 32'h0, 4'h0);
    drv_c(32'h0, 1'b0, 32'h0, 4'h0);
    drv_d(32'h0, 1'b0, 32'h0, 4'h0);
    tick(); tick();

    // Reset state
    check("rst_a_rdata",  64'(if_a.mem_rdata), 64'h0);
    check("rst_a_rvalid", 64'(if_a.mem_rvalid), 64'h0);
    check("rst_b_rbusy",  64'(if_b.mem_rbusy), 64'h0);
    check("rst_c_err",    64'(if_c.mem_err), 64'h0);
    check("rst_d_rdata",  64'(if_d.mem_rdata), 64'h0);

    @(negedge clk);
    resetn  = 1'b1;
    rst_d_n = 1'b1;
    tick();

    // ---------------- DUT A: latency 1, base 0 ----------------
    drv_a(32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    tick();
    drv_a(32'h10, 1'b1, 32'h0, 4'h0);
    tick();
    check("a_full_rdata",  64'(if_a.mem_rdata), 64'hDEADBEEF);
    check("a_full_rvalid", 64'(if_a.mem_rvalid), 64'h1);
    check("a_rbusy_lat1",  64'(if_a.mem_rbusy), 64'h0);
    drv_a(32'h0, 1'b0, 32'h0, 4'h0);
    tick();
    check("a_rvalid_pulse", 64'(if_a.mem_rvalid), 64'h0);
    check("a_rdata_hold",   64'(if_a.mem_rdata), 64'hDEADBEEF);
    check("a_no_err",       64'(if_a.mem_err), 64'h0);

    // Byte lanes 0 and 2 only
    drv_a(32'h20, 1'b0, 32'hFFFFFFFF, 4'hF);
    tick();
    drv_a(32'h20, 1'b0, 32'h11223344, 4'b0101);
    tick();
    drv_a(32'h20, 1'b1, 32'h0, 4'h0);
    tick();
    check("a_bytemask", 64'(if_a.mem_rdata), 64'hFF22FF44);

    // Read-before-write on the same word, then read of the new value
    drv_a(32'h30, 1'b0, 32'h0, 4'hF);
    tick();
    drv_a(32'h30, 1'b1, 32'hAAAA5555, 4'hF);
    tick();
    check("a_rbw_old",    64'(if_a.mem_rdata), 64'h0);
    check("a_rbw_valid",  64'(if_a.mem_rvalid), 64'h1);
    drv_a(32'h30, 1'b1, 32'h0, 4'h0);
    tick();
    check("a_rbw_new",    64'(if_a.mem_rdata), 64'hAAAA5555);
    check("a_b2b_valid",  64'(if_a.mem_rvalid), 64'h1);

    // Misaligned read: slot used, data zero, error one edge later
    drv_a(32'h22, 1'b1, 32'h0, 4'h0);
    tick();
    check("a_mis_rvalid", 64'(if_a.mem_rvalid), 64'h1);
    check("a_mis_rdata",  64'(if_a.mem_rdata), 64'h0);
    check("a_mis_err_t",  64'(if_a.mem_err), 64'h0);
    drv_a(32'h0, 1'b0, 32'h0, 4'h0);
    tick();
    check("a_mis_err_t1", 64'(if_a.mem_err), 64'h1);
    tick();
    check("a_mis_err_end", 64'(if_a.mem_err), 64'h0);

    // ---------------- DUT B: latency 3 ----------------
    drv_b(32'h0, 1'b0, 32'h1, 4'hF); tick();
    drv_b(32'h4, 1'b0, 32'h2, 4'hF); tick();
    drv_b(32'h8, 1'b0, 32'h3, 4'hF); tick();
    drv_b(32'h0, 1'b0, 32'h0, 4'h0);
    check("b_idle_busy", 64'(if_b.mem_rbusy), 64'h0);
    drv_b(32'h0, 1'b1, 32'h0, 4'h0); tick();
    check("b_c0_busy",  64'(if_b.mem_rbusy), 64'h1);
    check("b_c0_valid", 64'(if_b.mem_rvalid), 64'h0);
    drv_b(32'h4, 1'b1, 32'h0, 4'h0); tick();
    check("b_c1_busy",  64'(if_b.mem_rbusy), 64'h1);
    check("b_c1_valid", 64'(if_b.mem_rvalid), 64'h0);
    drv_b(32'h8, 1'b1, 32'h0, 4'h0); tick();
    check("b_c2_valid", 64'(if_b.mem_rvalid), 64'h1);
    check("b_c2_rdata", 64'(if_b.mem_rdata), 64'h1);
    check("b_c2_busy",  64'(if_b.mem_rbusy), 64'h1);
    drv_b(32'h0, 1'b0, 32'h0, 4'h0); tick();
    check("b_c3_valid", 64'(if_b.mem_rvalid), 64'h1);
    check("b_c3_rdata", 64'(if_b.mem_rdata), 64'h2);
    check("b_c3_busy",  64'(if_b.mem_rbusy), 64'h1);
    tick();
    check("b_c4_valid", 64'(if_b.mem_rvalid), 64'h1);
    check("b_c4_rdata", 64'(if_b.mem_rdata), 64'h3);
    check("b_c4_busy",  64'(if_b.mem_rbusy), 64'h0);
    tick();
    check("b_c5_valid", 64'(if_b.mem_rvalid), 64'h0);
    check("b_c5_rdata", 64'(if_b.mem_rdata), 64'h3);
    check("b_c5_busy",  64'(if_b.mem_rbusy), 64'h0);

    // ---------------- DUT C: base 0x1000, 16 words ----------------
    drv_c(32'h1000, 1'b0, 32'h55667788, 4'hF); tick();
    drv_c(32'h0FFC, 1'b1, 32'h0, 4'h0); tick();
    check("c_below_rvalid", 64'(if_c.mem_rvalid), 64'h1);
    check("c_below_rdata",  64'(if_c.mem_rdata), 64'h0);
    check("c_below_err_t",  64'(if_c.mem_err), 64'h0);
    drv_c(32'h1040, 1'b1, 32'h0, 4'h0); tick();
    check("c_below_err",    64'(if_c.mem_err), 64'h1);
    check("c_above_rdata",  64'(if_c.mem_rdata), 64'h0);
    drv_c(32'h1002, 1'b0, 32'hFFFFFFFF, 4'h1); tick();
    check("c_above_err",    64'(if_c.mem_err), 64'h1);
    check("c_wr_rvalid",    64'(if_c.mem_rvalid), 64'h0);
    drv_c(32'h1000, 1'b1, 32'h0, 4'h0); tick();
    check("c_miswr_err",    64'(if_c.mem_err), 64'h1);
    check("c_ram_unchanged", 64'(if_c.mem_rdata), 64'h55667788);
    drv_c(32'h103C, 1'b0, 32'hCAFEF00D, 4'hF); tick();
    check("c_good_err",     64'(if_c.mem_err), 64'h0);
    drv_c(32'h103C, 1'b1, 32'h0, 4'h0); tick();
    check("c_top_err",      64'(if_c.mem_err), 64'h0);
    drv_c(32'h0, 1'b0, 32'h0, 4'h0); tick();
    check("c_top_rdata",    64'(if_c.mem_rdata), 64'hCAFEF00D);
    check("c_top_err_t1",   64'(if_c.mem_err), 64'h0);

    // ---------------- DUT D: latency 4, async reset mid-burst ----------------
    drv_d(32'h0, 1'b0, 32'h12345678, 4'hF); tick();
    drv_d(32'h4, 1'b0, 32'h9ABCDEF0, 4'hF); tick();
    drv_d(32'h0, 1'b1, 32'h0, 4'h0); tick();
    drv_d(32'h4, 1'b1, 32'h0, 4'h0); tick();
    drv_d(32'h0, 1'b0, 32'h0, 4'h0);
    check("d_busy_inflight", 64'(if_d.mem_rbusy), 64'h1);
    #2 rst_d_n = 1'b0;
    #1;
    check("d_async_busy",   64'(if_d.mem_rbusy), 64'h0);
    check("d_async_valid",  64'(if_d.mem_rvalid), 64'h0);
    check("d_async_rdata",  64'(if_d.mem_rdata), 64'h0);
    tick(); tick();
    rst_d_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_d.mem_rvalid === 1'b1) rv_seen++;
    end
    check("d_no_rvalid_after_rst", 64'(rv_seen), 64'h0);
    drv_d(32'h4, 1'b1, 32'h0, 4'h0); tick();
    drv_d(32'h0, 1'b0, 32'h0, 4'h0);
    tick(); tick();
    check("d_lat_not_yet", 64'(if_d.mem_rvalid), 64'h0);
    tick();
    check("d_post_rvalid", 64'(if_d.mem_rvalid), 64'h1);
    check("d_post_rdata",  64'(if_d.mem_rdata), 64'h9ABCDEF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
